// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared branch types and branch-control constants
package ariane_pkg;

    // Default limit on control-flow instructions issued but not yet resolved
    localparam int unsigned NR_UNRESOLVED_BRANCHES = 2;

    typedef struct packed {
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        valid;
        logic [63:0] pc;
        logic        is_taken;
        logic        is_lower_16;
        logic        clear;
    } branchpredict_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redirect_state_e;

endpackage

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - unresolved-branch throttle, mispredict redirect and predictor update
module branch_resolve_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NR_BRANCHES = NR_UNRESOLVED_BRANCHES,
    parameter int unsigned CNT_W       = $clog2(NR_BRANCHES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             issue_branch_i,
    output logic             branch_issue_ready_o,
    input  logic             resolve_branch_i,
    input  branchpredict_t   resolved_branch_i,
    output logic             flush_unissued_o,
    output logic             flush_id_o,
    output logic             redirect_valid_o,
    output logic [63:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output branchpredict_t   bp_update_o,
    output logic             bp_update_valid_o,
    output logic [CNT_W-1:0] unresolved_cnt_o
);

    redirect_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             flush_pulse_q;
    logic             mispredict_accept;
    logic             issue_fire;

    // A mispredict only starts a redirect from IDLE; in REDIRECT younger branches are being flushed anyway
    assign mispredict_accept = (state_q == IDLE) && resolve_branch_i &&
                               resolved_branch_i.is_mispredict && !flush_i;

    assign branch_issue_ready_o = (state_q == IDLE) && (cnt_q < CNT_W'(NR_BRANCHES)) && !flush_i;
    assign issue_fire           = issue_branch_i && branch_issue_ready_o;

    // Next in-flight count: flush/mispredict clear it, otherwise +1/-1 with saturation at zero
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i || mispredict_accept) begin
            cnt_d = '0;
        end else if (issue_fire && !resolve_branch_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (resolve_branch_i && !issue_fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Redirect FSM, in-flight counter and the one-shot flush flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            flush_pulse_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            flush_pulse_q <= mispredict_accept;
            if (flush_i) begin
                state_q <= IDLE;
            end else if (mispredict_accept) begin
                state_q <= REDIRECT;
            end else if ((state_q == REDIRECT) && redirect_ready_i) begin
                state_q <= IDLE;
            end
        end
    end

    // Corrected fetch address, captured when the redirect starts and held until the next one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            redirect_pc_o <= '0;
        end else if (mispredict_accept) begin
            redirect_pc_o <= resolved_branch_i.target_address;
        end
    end

    // Predictor update register: one-cycle valid pulse, payload holds between updates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bp_update_o       <= '0;
            bp_update_valid_o <= 1'b0;
        end else begin
            bp_update_valid_o <= resolve_branch_i && resolved_branch_i.valid && !flush_i;
            if (resolve_branch_i && resolved_branch_i.valid && !flush_i) begin
                bp_update_o <= resolved_branch_i;
            end
        end
    end

    assign redirect_valid_o = (state_q == REDIRECT);
    assign flush_unissued_o = flush_pulse_q;
    assign flush_id_o       = flush_pulse_q;
    assign unresolved_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
    import ariane_pkg::*;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           issue_branch;
    logic           branch_issue_ready;
    logic           resolve_branch;
    branchpredict_t resolved_branch;
    logic           flush_unissued;
    logic           flush_id;
    logic           redirect_valid;
    logic [63:0]    redirect_pc;
    logic           redirect_ready;
    branchpredict_t bp_update;
    logic           bp_update_valid;
    logic [1:0]     unresolved_cnt;

    int checks   = 0;
    int failures = 0;
    branchpredict_t bp_q[$];

    branch_resolve_ctrl #(.NR_BRANCHES(2)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .flush_i              (flush),
        .issue_branch_i       (issue_branch),
        .branch_issue_ready_o (branch_issue_ready),
        .resolve_branch_i     (resolve_branch),
        .resolved_branch_i    (resolved_branch),
        .flush_unissued_o     (flush_unissued),
        .flush_id_o           (flush_id),
        .redirect_valid_o     (redirect_valid),
        .redirect_pc_o        (redirect_pc),
        .redirect_ready_i     (redirect_ready),
        .bp_update_o          (bp_update),
        .bp_update_valid_o    (bp_update_valid),
        .unresolved_cnt_o     (unresolved_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Scoreboard side: every predictor-update pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && bp_update_valid) begin
            checks++;
            if (bp_q.size() == 0) begin
                failures++;
                $display("FAIL bp_unexpected_pulse got pc=%h exp=no pulse", bp_update.pc);
            end else begin
                branchpredict_t e;
                e = bp_q.pop_front();
                if (bp_update !== e) begin
                    failures++;
                    $display("FAIL bp_payload got pc=%h tgt=%h tk=%b exp pc=%h tgt=%h tk=%b",
                             bp_update.pc, bp_update.target_address, bp_update.is_taken,
                             e.pc, e.target_address, e.is_taken);
                end
            end
        end
    end

    function automatic branchpredict_t mk_bp(input logic [63:0] tgt, input logic misp,
                                             input logic vld, input logic [63:0] pc,
                                             input logic tk);
        branchpredict_t b;
        b = '0;
        b.target_address = tgt;
        b.is_mispredict  = misp;
        b.valid          = vld;
        b.pc             = pc;
        b.is_taken       = tk;
        return b;
    endfunction

    task automatic drive(input logic iss, input logic res, input branchpredict_t bp,
                         input logic fl, input logic rdy);
        issue_branch    = iss;
        resolve_branch  = res;
        resolved_branch = bp;
        flush           = fl;
        redirect_ready  = rdy;
        if (res && bp.valid && !fl) bp_q.push_back(bp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++;
        if (redirect_valid !== 1'b0 || flush_unissued !== 1'b0 || flush_id !== 1'b0 ||
            bp_update_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_1bit got rv=%b fu=%b fi=%b bv=%b exp=0", redirect_valid,
                     flush_unissued, flush_id, bp_update_valid);
        end
        checks++;
        if (unresolved_cnt !== 2'd0 || redirect_pc !== 64'h0 || bp_update !== '0) begin
            failures++;
            $display("FAIL reset_regs got cnt=%0d pc=%h exp cnt=0 pc=0", unresolved_cnt, redirect_pc);
        end
        checks++;
        if (branch_issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", branch_issue_ready);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_issue_limit();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        idle();
        checks++;
        if (unresolved_cnt !== 2'd2 || branch_issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL issue_full got cnt=%0d rdy=%b exp cnt=2 rdy=0", unresolved_cnt, branch_issue_ready);
        end
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checks++;
        if (unresolved_cnt !== 2'd2) begin
            failures++;
            $display("FAIL issue_blocked got cnt=%0d exp=2", unresolved_cnt);
        end
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (unresolved_cnt !== 2'd1 || branch_issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL resolve_dec got cnt=%0d rdy=%b exp cnt=1 rdy=1", unresolved_cnt, branch_issue_ready);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b1, '0, 1'b0, 1'b0);
        tick();
        checks++;
        if (unresolved_cnt !== 2'd1) begin
            failures++;
            $display("FAIL issue_and_resolve got cnt=%0d exp=1", unresolved_cnt);
        end
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        tick();
        tick();
        idle();
        checks++;
        if (unresolved_cnt !== 2'd0) begin
            failures++;
            $display("FAIL resolve_at_zero got cnt=%0d exp=0", unresolved_cnt);
        end
    endtask

    task automatic test_mispredict();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b1, mk_bp(64'h8000_0040, 1'b1, 1'b1, 64'h80, 1'b1), 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0040) begin
            failures++;
            $display("FAIL misp_t1_redirect got rv=%b pc=%h exp rv=1 pc=80000040", redirect_valid, redirect_pc);
        end
        checks++;
        if (flush_unissued !== 1'b1 || flush_id !== 1'b1 || unresolved_cnt !== 2'd0) begin
            failures++;
            $display("FAIL misp_t1_flush got fu=%b fi=%b cnt=%0d exp 1 1 0", flush_unissued, flush_id, unresolved_cnt);
        end
        tick();
        checks++;
        if (flush_unissued !== 1'b0 || flush_id !== 1'b0 || redirect_valid !== 1'b1) begin
            failures++;
            $display("FAIL misp_t2 got fu=%b fi=%b rv=%b exp 0 0 1", flush_unissued, flush_id, redirect_valid);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        idle();
        checks++;
        if (redirect_valid !== 1'b0 || branch_issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL misp_t4_idle got rv=%b rdy=%b exp rv=0 rdy=1", redirect_valid, branch_issue_ready);
        end
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        drive(1'b0, 1'b1, mk_bp(64'h8000_1000, 1'b1, 1'b0, 64'h0, 1'b0), 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1'b1, 1'b1, mk_bp(64'h8000_2000, 1'b1, 1'b0, 64'h0, 1'b0), 1'b0, 1'b0);
            else        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
            #1;
            if (branch_issue_ready !== 1'b0) bad++;
            tick();
            if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_1000) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold got bad_cycles=%0d exp=0 (last rv=%b pc=%h)", bad, redirect_valid, redirect_pc);
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        checks++;
        if (redirect_valid !== 1'b0 || unresolved_cnt !== 2'd0 || flush_id !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got rv=%b cnt=%0d fi=%b exp 0 0 0", redirect_valid, unresolved_cnt, flush_id);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, mk_bp(64'h8000_3000, 1'b1, 1'b1, 64'h44, 1'b1), 1'b1, 1'b0);
        tick();
        idle();
        checks++;
        if (redirect_valid !== 1'b0 || flush_id !== 1'b0 || unresolved_cnt !== 2'd0 ||
            bp_update_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_vs_misp got rv=%b fi=%b cnt=%0d bv=%b exp 0 0 0 0",
                     redirect_valid, flush_id, unresolved_cnt, bp_update_valid);
        end
        drive(1'b0, 1'b1, mk_bp(64'h8000_4000, 1'b1, 1'b0, 64'h0, 1'b0), 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        idle();
        checks++;
        if (redirect_valid !== 1'b0 || flush_unissued !== 1'b0 || unresolved_cnt !== 2'd0) begin
            failures++;
            $display("FAIL flush_in_redirect got rv=%b fu=%b cnt=%0d exp 0 0 0",
                     redirect_valid, flush_unissued, unresolved_cnt);
        end
    endtask

    task automatic test_predictor();
        drive(1'b0, 1'b1, mk_bp(64'h104, 1'b0, 1'b1, 64'h100, 1'b1), 1'b0, 1'b0);
        tick();
        checks++;
        if (bp_update_valid !== 1'b1 || bp_update.pc !== 64'h100 || bp_update.is_taken !== 1'b1) begin
            failures++;
            $display("FAIL bp_first got v=%b pc=%h tk=%b exp 1 100 1", bp_update_valid, bp_update.pc, bp_update.is_taken);
        end
        drive(1'b0, 1'b1, mk_bp(64'h208, 1'b0, 1'b1, 64'h200, 1'b0), 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, mk_bp(64'h308, 1'b0, 1'b1, 64'h300, 1'b1), 1'b0, 1'b0);
        tick();
        checks++;
        if (bp_update_valid !== 1'b1 || bp_update.pc !== 64'h300) begin
            failures++;
            $display("FAIL bp_back_to_back got v=%b pc=%h exp 1 300", bp_update_valid, bp_update.pc);
        end
        drive(1'b0, 1'b1, mk_bp(64'h408, 1'b0, 1'b0, 64'h400, 1'b1), 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (bp_update_valid !== 1'b0 || bp_update.pc !== 64'h300) begin
            failures++;
            $display("FAIL bp_invalid_hold got v=%b pc=%h exp 0 300", bp_update_valid, bp_update.pc);
        end
    endtask

    task automatic test_reset_mid_redirect();
        drive(1'b0, 1'b1, mk_bp(64'h9000, 1'b1, 1'b0, 64'h0, 1'b0), 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (redirect_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_setup got rv=%b exp=1", redirect_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 64'h0 || bp_update !== '0 ||
            flush_id !== 1'b0 || unresolved_cnt !== 2'd0) begin
            failures++;
            $display("FAIL rst_async got rv=%b pc=%h bp_pc=%h fi=%b cnt=%0d exp all 0",
                     redirect_valid, redirect_pc, bp_update.pc, flush_id, unresolved_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_issue_limit();
        test_simultaneous();
        test_mispredict();
        test_stall();
        test_flush();
        test_predictor();
        test_reset_mid_redirect();
        checks++;
        if (bp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_missing_pulses got pending=%0d exp=0", bp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
